// File: rtl/program_loader.sv
// Streams host instruction words into instruction memory, holding the core until the load completes.
// Writes land one cycle after accept; in_ready drops outside LOAD, so the host stalls during idle/flush.
module program_loader #(
  parameter int DEPTH       = 8,
  parameter int ADDR_W      = 3,
  parameter int DATA_W      = 12,
  parameter int START_DELAY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [DATA_W-1:0] im_wdata,
  output logic              cpu_hold,
  output logic              cpu_start,
  output logic [ADDR_W:0]   word_count,
  output logic              overflow_err
);

  localparam int CNT_W = (START_DELAY < 2) ? 1 : $clog2(START_DELAY + 1);
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [CNT_W-1:0]    flush_q, flush_d;
  logic                ovf_q, ovf_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                start_q, start_d;
  logic                ready_q, ready_d;
  logic                hold_q, hold_d;
  logic                accept;
  logic                full;

  assign accept = in_valid & ready_q;
  assign full   = (count_q == FULL_CNT);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    flush_d = flush_q;
    ovf_d   = ovf_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_req) begin
          state_d = LOAD;
          ptr_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      LOAD: begin
        if (accept) begin
          if (!full) begin
            we_d    = 1'b1;
            waddr_d = ptr_q;
            wdata_d = in_data;
            count_d = count_q + 1'b1;
            // Saturate instead of wrapping so a full memory never rewrites address 0.
            if (ptr_q != LAST_PTR) ptr_d = ptr_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
          if (in_last) begin
            state_d = FLUSH;
            flush_d = CNT_W'(START_DELAY);
          end
        end
      end
      FLUSH: begin
        flush_d = flush_q - 1'b1;
        if (flush_q == CNT_W'(1)) begin
          state_d = IDLE;
          start_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == LOAD);
    hold_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      count_q <= '0;
      flush_q <= '0;
      ovf_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      start_q <= 1'b0;
      ready_q <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      flush_q <= flush_d;
      ovf_q   <= ovf_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      start_q <= start_d;
      ready_q <= ready_d;
      hold_q  <= hold_d;
    end
  end

  assign in_ready     = ready_q;
  assign im_we        = we_q;
  assign im_waddr     = waddr_q;
  assign im_wdata     = wdata_q;
  assign cpu_hold     = hold_q;
  assign cpu_start    = start_q;
  assign word_count   = count_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: session-level reference model compared every cycle,
// plus literal expectations on the memory image, counts and start timing.
module tb_program_loader;
  localparam int DEPTH = 8;
  localparam int SD    = 2;

  logic        clk = 1'b0;
  logic        rst, load_req, in_valid, in_last;
  logic [11:0] in_data;
  logic        in_ready, im_we, cpu_hold, cpu_start, overflow_err;
  logic [2:0]  im_waddr;
  logic [11:0] im_wdata;
  logic [3:0]  word_count;

  program_loader #(.DEPTH(8), .ADDR_W(3), .DATA_W(12), .START_DELAY(SD)) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready), .im_we(im_we),
    .im_waddr(im_waddr), .im_wdata(im_wdata), .cpu_hold(cpu_hold),
    .cpu_start(cpu_start), .word_count(word_count), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit started = 0;

  // Reference: session phase (0 idle, 1 loading, 2 waiting for release) plus words written.
  int m_phase, m_count, m_waddr, m_wdata, m_release;
  bit m_we, m_start, m_ovf;

  int we_cnt = 0;
  int starts = 0;
  int last_waddr = -1;
  int last_wdata = -1;
  int shadow [8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  initial begin
    m_phase = 0; m_count = 0; m_waddr = 0; m_wdata = 0; m_release = 0;
    m_we = 0; m_start = 0; m_ovf = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_phase = 0; m_count = 0; m_waddr = 0; m_wdata = 0;
        m_we = 0; m_start = 0; m_ovf = 0;
      end else begin
        m_we = 0;
        m_start = 0;
        if (m_phase == 0) begin
          if (load_req) begin
            m_phase = 1; m_count = 0; m_ovf = 0;
          end
        end else if (m_phase == 1) begin
          if (in_valid) begin
            if (m_count < DEPTH) begin
              m_we = 1; m_waddr = m_count; m_wdata = int'(in_data); m_count++;
            end else begin
              m_ovf = 1;
            end
            if (in_last) begin
              m_phase = 2;
              m_release = cyc + SD;
            end
          end
        end else if (cyc == m_release) begin
          m_phase = 0;
          m_start = 1;
        end
      end
      started = 1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("in_ready",     int'(in_ready),     int'(m_phase == 1));
        chk("cpu_hold",     int'(cpu_hold),     int'(m_phase != 0));
        chk("cpu_start",    int'(cpu_start),    int'(m_start));
        chk("im_we",        int'(im_we),        int'(m_we));
        chk("im_waddr",     int'(im_waddr),     m_waddr);
        chk("im_wdata",     int'(im_wdata),     m_wdata);
        chk("word_count",   int'(word_count),   m_count);
        chk("overflow_err", int'(overflow_err), int'(m_ovf));
        if (im_we) begin
          we_cnt++;
          last_waddr = int'(im_waddr);
          last_wdata = int'(im_wdata);
          shadow[im_waddr] = int'(im_wdata);
        end
        if (cpu_start) starts++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [11:0] d, input logic last, output int acc);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    step();
    acc      = cyc;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic begin_session();
    we_cnt   = 0;
    starts   = 0;
    load_req = 1'b1;
    step();
    load_req = 1'b0;
  endtask

  task automatic wait_start(input int acc, input string tag);
    bit seen;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (cpu_start) begin
        seen = 1;
        break;
      end
      step();
    end
    chk({tag, "_start_seen"}, int'(seen), 1);
    if (seen) begin
      chk({tag, "_start_delay"}, cyc - acc, 2);
      chk({tag, "_hold_at_start"}, int'(cpu_hold), 0);
    end
    step();
    chk({tag, "_start_pulses"}, starts, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    logic [11:0] prog [3];
    bit          gv   [4];
    logic [11:0] gd   [4];
    for (int i = 0; i < 8; i++) shadow[i] = -1;
    prog[0] = 12'hA01; prog[1] = 12'h0B2; prog[2] = 12'hFFF;
    gv[0] = 1; gv[1] = 0; gv[2] = 0; gv[3] = 1;
    gd[0] = 12'h111; gd[1] = 12'h222; gd[2] = 12'h333; gd[3] = 12'h444;
    rst = 1'b1; load_req = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    step(); step();
    chk("reset_ready", int'(in_ready), 0);
    chk("reset_hold",  int'(cpu_hold), 0);
    chk("reset_count", int'(word_count), 0);
    rst = 1'b0;
    step();

    // Normal three-word load with continuous valid.
    begin_session();
    chk("load_ready", int'(in_ready), 1);
    chk("load_hold",  int'(cpu_hold), 1);
    for (int i = 0; i < 3; i++) send(prog[i], (i == 2), acc);
    wait_start(acc, "normal");
    chk("normal_writes", we_cnt, 3);
    chk("normal_count", int'(word_count), 3);
    chk("normal_m0", shadow[0], 12'hA01);
    chk("normal_m1", shadow[1], 12'h0B2);
    chk("normal_m2", shadow[2], 12'hFFF);

    // Gaps in in_valid: only two accepted words.
    begin_session();
    for (int i = 0; i < 4; i++) begin
      in_valid = gv[i];
      in_data  = gd[i];
      in_last  = (i == 3);
      step();
      acc = cyc;
    end
    in_valid = 1'b0; in_last = 1'b0;
    wait_start(acc, "gaps");
    chk("gaps_writes", we_cnt, 2);
    chk("gaps_count", int'(word_count), 2);
    chk("gaps_m0", shadow[0], 12'h111);
    chk("gaps_m1", shadow[1], 12'h444);

    // Nine words into an eight-entry memory.
    begin_session();
    for (int i = 0; i < 9; i++) send(12'h100 + 12'(i), (i == 8), acc);
    wait_start(acc, "full");
    chk("full_writes", we_cnt, 8);
    chk("full_count", int'(word_count), 8);
    chk("full_ovf", int'(overflow_err), 1);
    for (int i = 0; i < 8; i++) chk("full_mem", shadow[i], 12'h100 + i);
    chk("full_last_addr", last_waddr, 7);

    // New request clears overflow; stray load_req and idle in_valid are ignored.
    begin_session();
    chk("ovf_cleared", int'(overflow_err), 0);
    chk("count_cleared", int'(word_count), 0);
    load_req = 1'b1;
    step();
    load_req = 1'b1;
    send(12'h5A5, 1'b1, acc);
    chk("flush_ready", int'(in_ready), 0);
    step();
    load_req = 1'b0;
    wait_start(acc, "single");
    chk("single_writes", we_cnt, 1);
    chk("single_count", int'(word_count), 1);
    chk("single_m0", shadow[0], 12'h5A5);
    in_valid = 1'b1; in_data = 12'hBAD;
    repeat (3) step();
    in_valid = 1'b0;
    chk("idle_writes", we_cnt, 1);
    chk("idle_ready", int'(in_ready), 0);
    chk("idle_hold", int'(cpu_hold), 0);

    // Reset in the middle of a session.
    begin_session();
    send(12'h321, 1'b0, acc);
    send(12'h654, 1'b0, acc);
    rst = 1'b1;
    step(); step();
    chk("mid_rst_ready", int'(in_ready), 0);
    chk("mid_rst_hold",  int'(cpu_hold), 0);
    chk("mid_rst_count", int'(word_count), 0);
    chk("mid_rst_addr",  int'(im_waddr), 0);
    chk("mid_rst_data",  int'(im_wdata), 0);
    chk("mid_rst_we",    int'(im_we), 0);
    rst = 1'b0;
    step();
    begin_session();
    send(12'h777, 1'b1, acc);
    wait_start(acc, "after_rst");
    chk("after_rst_addr", last_waddr, 0);
    chk("after_rst_data", last_wdata, 12'h777);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
